// File: rtl/fifo_scheduler.sv
// fifo_scheduler
//   Schedules a single FIFO port between NREQ round-robin write requesters
//   and one consumer. It issues at most one operation per cycle, tracks FIFO
//   occupancy itself, and flags any strobe that hits a full/empty FIFO.
//
// Ports
//   clk     : clock, all state updates on the rising edge
//   rst     : asynchronous active-high reset
//   req     : per-requester write request (level, held until granted)
//   rd_req  : consumer read request (level)
//   full    : FIFO full flag, used only for the protocol-error check
//   emp     : FIFO empty flag, used only for the protocol-error check
//   wr      : write strobe, one cycle per write
//   rd      : read strobe, one cycle per read
//   gnt     : one-hot grant, high in the same cycle as wr
//   gnt_id  : binary index of gnt, 0 when no grant
//   count   : scheduler-tracked occupancy (0 .. 2**addresswidth)
//   err     : sticky protocol-error flag, cleared only by rst
module fifo_scheduler #(
  parameter int NREQ         = 4,
  parameter int addresswidth = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    rd_req,
  input  logic                    full,
  input  logic                    emp,
  output logic                    wr,
  output logic                    rd,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic [addresswidth:0]   count,
  output logic                    err
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = addresswidth + 1;

  localparam logic [CW-1:0]   L_DEPTH    = {1'b1, {addresswidth{1'b0}}};
  localparam logic [CW-1:0]   L_CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   L_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [IDW:0]    L_NREQ     = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0]  L_LAST_IDX = IDW'(NREQ - 1);
  localparam logic [IDW-1:0]  L_IDX_ONE  = {{(IDW-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0] L_GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10
  } state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_t;

  state_t          r_state;
  op_t             r_last_op;
  logic [IDW-1:0]  r_rr_ptr;
  logic [NREQ-1:0] r_gnt;
  logic [IDW-1:0]  r_gnt_id;
  logic [CW-1:0]   r_count;
  logic            r_err;

  logic            w_found;
  logic [IDW-1:0]  w_gnt_idx;
  logic [IDW:0]    w_sum;
  logic            w_wr_elig;
  logic            w_rd_elig;
  logic            w_do_wr;
  logic            w_do_rd;

  // Round-robin search: first requester at or after r_rr_ptr, wrapping at NREQ.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = {IDW{1'b0}};
    w_sum     = {(IDW+1){1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= L_NREQ) begin
        w_sum = w_sum - L_NREQ;
      end else begin
        w_sum = w_sum;
      end
      if (!w_found && req[w_sum[IDW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[IDW-1:0];
      end else begin
        w_found   = w_found;
      end
    end
  end

  // Eligibility and tie-break: on a tie the op opposite to the last one wins.
  always_comb begin
    w_wr_elig = w_found && (r_count != L_DEPTH);
    w_rd_elig = rd_req && (r_count != L_CNT_ZERO);
    w_do_wr   = w_wr_elig && (!w_rd_elig || (r_last_op == OP_READ));
    w_do_rd   = w_rd_elig && !w_do_wr;
  end

  // Scheduler FSM: state holds the op issued this cycle; count/grant move with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_last_op <= OP_READ;
      r_rr_ptr  <= {IDW{1'b0}};
      r_gnt     <= {NREQ{1'b0}};
      r_gnt_id  <= {IDW{1'b0}};
      r_count   <= L_CNT_ZERO;
      r_err     <= 1'b0;
    end else begin
      // Strobes seen by the FIFO this cycle are checked against its flags.
      if ((wr && full) || (rd && emp)) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end

      case ({w_do_wr, w_do_rd})
        2'b10: begin
          r_state   <= ST_WRITE;
          r_last_op <= OP_WRITE;
          r_gnt     <= L_GNT_ONE << w_gnt_idx;
          r_gnt_id  <= w_gnt_idx;
          r_count   <= r_count + L_CNT_ONE;
          if (w_gnt_idx == L_LAST_IDX) begin
            r_rr_ptr <= {IDW{1'b0}};
          end else begin
            r_rr_ptr <= w_gnt_idx + L_IDX_ONE;
          end
        end
        2'b01: begin
          r_state   <= ST_READ;
          r_last_op <= OP_READ;
          r_gnt     <= {NREQ{1'b0}};
          r_gnt_id  <= {IDW{1'b0}};
          r_count   <= r_count - L_CNT_ONE;
          r_rr_ptr  <= r_rr_ptr;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_last_op <= r_last_op;
          r_gnt     <= {NREQ{1'b0}};
          r_gnt_id  <= {IDW{1'b0}};
          r_count   <= r_count;
          r_rr_ptr  <= r_rr_ptr;
        end
      endcase
    end
  end

  // Strobes are pure decodes of the state register, so no input reaches them.
  assign wr     = (r_state == ST_WRITE);
  assign rd     = (r_state == ST_READ);
  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign count  = r_count;
  assign err    = r_err;

endmodule

// File: tb/tb_fifo_scheduler.sv
// tb_fifo_scheduler
//   Self-checking bench for fifo_scheduler (NREQ=4, addresswidth=5).
//   A behavioural model predicts each cycle's wr/rd/gnt/gnt_id/count when the
//   inputs are driven and pushes it to a queue; each test pops and compares
//   after the clock edge. A simple FIFO occupancy model drives full/emp.
module tb_fifo_scheduler;

  localparam int NREQ  = 4;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       rd_req;
  logic       full;
  logic       emp;
  logic       wr;
  logic       rd;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic [5:0] count;
  logic       err;

  logic       force_full;
  int         occ;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic [5:0] count;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t obs;
  int   n_checks;
  int   n_fail;

  // model state
  int   m_count;
  int   m_ptr;
  bit   m_last_rd;

  fifo_scheduler #(.NREQ(NREQ), .addresswidth(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .rd_req (rd_req),
    .full   (full),
    .emp    (emp),
    .wr     (wr),
    .rd     (rd),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .count  (count),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conforming FIFO: accepts the strobe present during each cycle at its end.
  always @(posedge clk or posedge rst) begin
    if (rst) occ <= 0;
    else     occ <= occ + (wr ? 1 : 0) - (rd ? 1 : 0);
  end
  assign full = force_full | (occ == DEPTH);
  assign emp  = (occ == 0);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs for the next edge and push the model's prediction.
  task automatic drive_cycle(input logic [3:0] rq, input logic rr);
    exp_t x;
    bit   we, re, dw, dr;
    int   idx;
    req    = rq;
    rd_req = rr;
    we = (rq != 4'b0000) && (m_count != DEPTH);
    re = rr && (m_count != 0);
    dw = we && (!re || m_last_rd);
    dr = re && !dw;
    x  = '0;
    if (dw) begin
      idx = m_ptr;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (rq[idx]) break;
      end
      x.wr      = 1'b1;
      x.gnt     = 4'(1 << idx);
      x.gnt_id  = 2'(idx);
      m_ptr     = (idx + 1) % NREQ;
      m_count   = m_count + 1;
      m_last_rd = 1'b0;
    end else if (dr) begin
      x.rd      = 1'b1;
      m_count   = m_count - 1;
      m_last_rd = 1'b1;
    end
    x.count = 6'(m_count);
    q.push_back(x);
  endtask

  task automatic model_reset();
    m_count   = 0;
    m_ptr     = 0;
    m_last_rd = 1'b1;
    q.delete();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req        = 4'b0000;
    rd_req     = 1'b0;
    force_full = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req        = 4'b0000;
    rd_req     = 1'b0;
    force_full = 1'b0;
    cyc();
    n_checks++;
    if ({wr, rd, gnt, gnt_id, count, err} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_state: wr=%b rd=%b gnt=%b id=%0d count=%0d err=%b, expected all 0",
               wr, rd, gnt, gnt_id, count, err);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(4'b1111, 1'b0);
      cyc();
      e = q.pop_front();
      obs = {wr, rd, gnt, gnt_id, count};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_burst[%0d]: got wr/rd/gnt/id/count=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                 i, wr, rd, gnt, gnt_id, count, e.wr, e.rd, e.gnt, e.gnt_id, e.count);
      end
    end
    // Mid-burst asynchronous reset, checked before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({wr, rd, gnt, gnt_id, count, err} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_async: wr=%b rd=%b gnt=%b id=%0d count=%0d err=%b, expected all 0",
               wr, rd, gnt, gnt_id, count, err);
    end
    cyc();
    rst = 1'b0;
    model_reset();
    // First decision happens at the first edge with rst low.
    drive_cycle(4'b0100, 1'b0);
    cyc();
    e = q.pop_front();
    obs = {wr, rd, gnt, gnt_id, count};
    n_checks++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_first_decision: got wr/rd/gnt/id/count=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
               wr, rd, gnt, gnt_id, count, e.wr, e.rd, e.gnt, e.gnt_id, e.count);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] seq;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(4'b1111, 1'b0);
      cyc();
      e = q.pop_front();
      obs = {wr, rd, gnt, gnt_id, count};
      seq = 4'b0001 << (i % 4);
      n_checks++;
      if ((obs !== e) || (gnt !== seq)) begin
        n_fail++;
        $display("FAIL rr[%0d]: got wr/rd/gnt/id/count=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                 i, wr, rd, gnt, gnt_id, count, e.wr, e.rd, seq, e.gnt_id, e.count);
      end
    end
    n_checks++;
    if (count !== 6'd8) begin
      n_fail++;
      $display("FAIL rr_count: got %0d, expected 8", count);
    end
  endtask

  task automatic test_fill();
    int n_wr;
    n_wr = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive_cycle(4'b0001, 1'b0);
      cyc();
      if (wr) n_wr++;
      e = q.pop_front();
      obs = {wr, rd, gnt, gnt_id, count};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL fill[%0d]: got wr/rd/gnt/id/count=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                 i, wr, rd, gnt, gnt_id, count, e.wr, e.rd, e.gnt, e.gnt_id, e.count);
      end
    end
    n_checks++;
    if ((n_wr != 32) || (wr !== 1'b0) || (count !== 6'd32) || (err !== 1'b0)) begin
      n_fail++;
      $display("FAIL fill_end: got pulses=%0d wr=%b count=%0d err=%b, expected 32/0/32/0",
               n_wr, wr, count, err);
    end
  endtask

  task automatic test_tie();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(4'b0010, 1'b0);
      cyc();
      void'(q.pop_front());
    end
    drive_cycle(4'b0000, 1'b1);
    cyc();
    void'(q.pop_front());
    n_checks++;
    if ((count !== 6'd3) || (rd !== 1'b1)) begin
      n_fail++;
      $display("FAIL tie_setup: got count=%0d rd=%b, expected 3/1", count, rd);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(4'b0010, 1'b1);
      cyc();
      e = q.pop_front();
      obs = {wr, rd, gnt, gnt_id, count};
      n_checks++;
      if ((obs !== e) || (wr !== (i % 2 == 0)) || (count !== ((i % 2 == 0) ? 6'd4 : 6'd3)) ||
          (wr && rd)) begin
        n_fail++;
        $display("FAIL tie[%0d]: got wr/rd/gnt/id/count=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                 i, wr, rd, gnt, gnt_id, count, e.wr, e.rd, e.gnt, e.gnt_id, e.count);
      end
    end
  endtask

  task automatic test_empty_guard();
    int n_rd;
    n_rd = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 3) drive_cycle(4'b0001, 1'b1);
      else        drive_cycle(4'b0000, 1'b1);
      cyc();
      if (rd) n_rd++;
      e = q.pop_front();
      obs = {wr, rd, gnt, gnt_id, count};
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL empty[%0d]: got wr/rd/gnt/id/count=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                 i, wr, rd, gnt, gnt_id, count, e.wr, e.rd, e.gnt, e.gnt_id, e.count);
      end
    end
    n_checks++;
    if ((n_rd != 1) || (count !== 6'd0)) begin
      n_fail++;
      $display("FAIL empty_end: got reads=%0d count=%0d, expected 1/0", n_rd, count);
    end
  endtask

  task automatic test_random();
    logic [3:0] rq;
    logic       rr;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rq = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rq = 4'b0000;
      rr = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
      drive_cycle(rq, rr);
      cyc();
      e = q.pop_front();
      obs = {wr, rd, gnt, gnt_id, count};
      n_checks++;
      if ((obs !== e) || (wr && rd)) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%b rd_req=%b got wr/rd/gnt/id/count=%b/%b/%b/%0d/%0d, expected %b/%b/%b/%0d/%0d",
                 i, rq, rr, wr, rd, gnt, gnt_id, count, e.wr, e.rd, e.gnt, e.gnt_id, e.count);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL random_err: got %b, expected 0", err);
    end
  endtask

  task automatic test_error();
    do_reset();
    force_full = 1'b1;
    drive_cycle(4'b0001, 1'b0);
    cyc();
    void'(q.pop_front());
    n_checks++;
    if ((wr !== 1'b1) || (err !== 1'b0)) begin
      n_fail++;
      $display("FAIL err_pre: got wr=%b err=%b, expected 1/0", wr, err);
    end
    drive_cycle(4'b0000, 1'b0);
    cyc();
    void'(q.pop_front());
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got %b, expected 1", err);
    end
    force_full = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, expected 1", err);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b, expected 0", err);
    end
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_round_robin();
    test_fill();
    test_tie();
    test_empty_guard();
    test_random();
    test_error();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
